// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types.
// Holds the pipeline-latch state encoding, its occupancy limit and decode helper,
// and the per-stage payload structs that stage interfaces cast to a latch DATA_W.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    SKID
  } pipe_latch_state_t;

  localparam int unsigned PIPE_LATCH_MAX_OCC = 2;

  // Decode-to-exec payload; 128 bits wide so it fits the default latch payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } exec_latch_t;

  // Number of entries held in each latch state.
  function automatic logic [1:0] pipe_latch_occ(input pipe_latch_state_t s);
    logic [1:0] occ;
    occ = 2'd0;
    unique case (s)
      EMPTY:   occ = 2'd0;
      FULL:    occ = 2'd1;
      SKID:    occ = 2'(PIPE_LATCH_MAX_OCC);
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   CLK   - clock
//   nRST  - asynchronous active-low reset, clears the count
//   en    - add inc this cycle
//   inc   - increment amount, 0..3
//   count - current value; sticks at all-ones, never wraps
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en,
  input  logic [1:0]       inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] max_val;

  // Two guard bits so the overflow test never wraps itself.
  assign sum     = {2'b00, count_q} + {{WIDTH{1'b0}}, inc};
  assign max_val = {2'b00, {WIDTH{1'b1}}};

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (sum > max_val) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_latch_skid.sv
// Generic pipeline register with valid/ready handshake and a one-entry skid buffer.
// Upstream backpressure (in_ready) is a pure decode of registered state, so it has
// no combinational path from out_ready, stall or flush.
// Ports:
//   CLK, nRST                      - clock, asynchronous active-low reset
//   in_valid/in_ready              - upstream handshake
//   in_data/in_track               - upstream payload and tracker word
//   out_valid/out_ready            - downstream handshake
//   out_data/out_track             - presented entry (main register)
//   stall                          - hazard hold, blocks the downstream transfer
//   flush                          - drop every held entry and any incoming one
//   occupancy                      - entries held, 0..2
//   stall_cycles, flush_drops      - saturating performance counters
module pipe_latch_skid
  import cpu_types_pkg::*;
#(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TRACK_W = 96,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [TRACK_W-1:0] in_track,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [TRACK_W-1:0] out_track,
  input  logic               stall,
  input  logic               flush,
  output logic [1:0]         occupancy,
  output logic [COUNT_W-1:0] stall_cycles,
  output logic [COUNT_W-1:0] flush_drops
);

  pipe_latch_state_t  state_q, state_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [TRACK_W-1:0] main_track_q, main_track_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [TRACK_W-1:0] skid_track_q, skid_track_d;

  logic in_fire, out_fire;

  // Output decode.
  always_comb begin
    in_ready  = (state_q != SKID);
    out_valid = (state_q != EMPTY) & ~flush;
    occupancy = pipe_latch_occ(state_q);
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~stall;

  // Next-state and datapath. Main is zeroed whenever the latch empties, so the
  // outputs show a clean bubble without extra gating.
  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_track_d = main_track_q;
    skid_data_d  = skid_data_q;
    skid_track_d = skid_track_q;
    if (flush) begin
      state_d      = EMPTY;
      main_data_d  = '0;
      main_track_d = '0;
      skid_data_d  = '0;
      skid_track_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = FULL;
            main_data_d  = in_data;
            main_track_d = in_track;
          end
        end
        FULL: begin
          if (out_fire && in_fire) begin
            main_data_d  = in_data;
            main_track_d = in_track;
          end else if (out_fire) begin
            state_d      = EMPTY;
            main_data_d  = '0;
            main_track_d = '0;
          end else if (in_fire) begin
            state_d      = SKID;
            skid_data_d  = in_data;
            skid_track_d = in_track;
          end
        end
        SKID: begin
          if (out_fire) begin
            state_d      = FULL;
            main_data_d  = skid_data_q;
            main_track_d = skid_track_q;
            skid_data_d  = '0;
            skid_track_d = '0;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= EMPTY;
      main_data_q  <= '0;
      main_track_q <= '0;
      skid_data_q  <= '0;
      skid_track_q <= '0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_track_q <= main_track_d;
      skid_data_q  <= skid_data_d;
      skid_track_q <= skid_track_d;
    end
  end

  assign out_data  = main_data_q;
  assign out_track = main_track_q;

  // Flush takes priority, so a stalled cycle that is also flushed is not counted.
  logic stall_en;
  assign stall_en = (state_q != EMPTY) & stall & ~flush;

  sat_counter #(
    .WIDTH(COUNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .en   (stall_en),
    .inc  (2'd1),
    .count(stall_cycles)
  );

  sat_counter #(
    .WIDTH(COUNT_W)
  ) u_drop_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .en   (flush),
    .inc  (occupancy),
    .count(flush_drops)
  );

endmodule

// File: tb/tb_pipe_latch_skid.sv
module tb_pipe_latch_skid;

  localparam int unsigned DW  = 128;
  localparam int unsigned TW  = 96;
  localparam int unsigned CW  = 16;
  localparam int unsigned CWS = 4;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          in_valid, out_ready, stall, flush;
  logic [DW-1:0] in_data;
  logic [TW-1:0] in_track;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_track;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cycles, flush_drops;

  logic           s_in_ready, s_out_valid;
  logic [DW-1:0]  s_out_data;
  logic [TW-1:0]  s_out_track;
  logic [1:0]     s_occupancy;
  logic [CWS-1:0] s_stall_cycles, s_flush_drops;

  always #5 CLK = ~CLK;

  pipe_latch_skid #(.DATA_W(DW), .TRACK_W(TW), .COUNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_track(in_track), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_track(out_track), .stall(stall), .flush(flush), .occupancy(occupancy),
    .stall_cycles(stall_cycles), .flush_drops(flush_drops)
  );

  // Narrow-counter copy, same stimulus, to exercise saturation.
  pipe_latch_skid #(.DATA_W(DW), .TRACK_W(TW), .COUNT_W(CWS)) dut_s (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_track(in_track), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_track(s_out_track), .stall(stall), .flush(flush),
    .occupancy(s_occupancy), .stall_cycles(s_stall_cycles), .flush_drops(s_flush_drops)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] trk(input logic [31:0] d);
    return (d == 32'd0) ? '0 : {d, ~d, d};
  endfunction

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        stl;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  eocc;
    logic        erdy;
    logic [15:0] est;
    logic [15:0] edr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic ordy,
                              input logic stl, input logic fl, input logic ev,
                              input logic [31:0] ed, input logic [1:0] eocc,
                              input logic erdy, input logic [15:0] est,
                              input logic [15:0] edr);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.stl = stl; v.fl = fl;
    v.ev = ev; v.ed = ed; v.eocc = eocc; v.erdy = erdy; v.est = est; v.edr = edr;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] id, input logic ordy,
                       input logic stl, input logic fl);
    in_valid  = iv;
    in_data   = {96'd0, id};
    in_track  = iv ? trk(id) : '0;
    out_ready = ordy;
    stall     = stl;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, " in_ready"}, 128'(in_ready), 128'(1'b1));
    chk({tag, " out_valid"}, 128'(out_valid), 128'(1'b0));
    chk({tag, " occupancy"}, 128'(occupancy), 128'(2'd0));
    chk({tag, " out_data"}, 128'(out_data), 128'd0);
    chk({tag, " stall_cycles"}, 128'(stall_cycles), 128'd0);
    chk({tag, " flush_drops"}, 128'(flush_drops), 128'd0);
    chk({tag, " narrow stall_cycles"}, 128'(s_stall_cycles), 128'd0);
  endtask

  initial begin
    nRST = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    #2;
    check_reset_outs("por");
    #10;
    nRST = 1'b1;
    step();

    // iv id ordy stl fl | ev ed occ rdy stall drops
    vecs.push_back(mk(1, 32'd1, 1, 0, 0, 0, 32'd0, 2'd0, 1, 16'd0, 16'd0));
    for (int k = 1; k <= 7; k++) begin
      vecs.push_back(mk(1, 32'(k + 1), 1, 0, 0, 1, 32'(k), 2'd1, 1, 16'd0, 16'd0));
    end
    vecs.push_back(mk(0, 32'd0, 1, 0, 0, 1, 32'd8, 2'd1, 1, 16'd0, 16'd0));
    vecs.push_back(mk(0, 32'd0, 1, 0, 0, 0, 32'd0, 2'd0, 1, 16'd0, 16'd0));
    // Skid: A loaded, B absorbed under stall, C held upstream.
    vecs.push_back(mk(1, 32'hA, 1, 0, 0, 0, 32'd0, 2'd0, 1, 16'd0, 16'd0));
    vecs.push_back(mk(1, 32'hB, 1, 1, 0, 1, 32'hA, 2'd1, 1, 16'd0, 16'd0));
    vecs.push_back(mk(1, 32'hC, 1, 1, 0, 1, 32'hA, 2'd2, 0, 16'd1, 16'd0));
    vecs.push_back(mk(1, 32'hC, 1, 0, 0, 1, 32'hA, 2'd2, 0, 16'd2, 16'd0));
    vecs.push_back(mk(1, 32'hC, 1, 0, 0, 1, 32'hB, 2'd1, 1, 16'd2, 16'd0));
    vecs.push_back(mk(0, 32'd0, 1, 0, 0, 1, 32'hC, 2'd1, 1, 16'd2, 16'd0));
    vecs.push_back(mk(0, 32'd0, 1, 0, 0, 0, 32'd0, 2'd0, 1, 16'd2, 16'd0));
    // Flush with two held entries while D is offered.
    vecs.push_back(mk(1, 32'h21, 0, 0, 0, 0, 32'd0, 2'd0, 1, 16'd2, 16'd0));
    vecs.push_back(mk(1, 32'h22, 0, 0, 0, 1, 32'h21, 2'd1, 1, 16'd2, 16'd0));
    vecs.push_back(mk(1, 32'hDD, 1, 0, 1, 0, 32'h21, 2'd2, 0, 16'd2, 16'd0));
    vecs.push_back(mk(0, 32'd0, 1, 0, 0, 0, 32'd0, 2'd0, 1, 16'd2, 16'd2));
    // Flush while FULL drops the concurrent in_fire; flush while EMPTY adds nothing.
    vecs.push_back(mk(1, 32'h31, 0, 0, 0, 0, 32'd0, 2'd0, 1, 16'd2, 16'd2));
    vecs.push_back(mk(1, 32'h32, 0, 0, 1, 0, 32'h31, 2'd1, 1, 16'd2, 16'd2));
    vecs.push_back(mk(0, 32'd0, 0, 0, 1, 0, 32'd0, 2'd0, 1, 16'd2, 16'd3));
    vecs.push_back(mk(0, 32'd0, 0, 0, 0, 0, 32'd0, 2'd0, 1, 16'd2, 16'd3));
    // Stall and flush together: flush wins, stall not counted.
    vecs.push_back(mk(1, 32'h41, 1, 0, 0, 0, 32'd0, 2'd0, 1, 16'd2, 16'd3));
    vecs.push_back(mk(0, 32'd0, 1, 1, 1, 0, 32'h41, 2'd1, 1, 16'd2, 16'd3));
    vecs.push_back(mk(0, 32'd0, 1, 0, 0, 0, 32'd0, 2'd0, 1, 16'd2, 16'd4));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].stl, vecs[i].fl);
      #1;
      chk($sformatf("v%0d out_valid", i), 128'(out_valid), 128'(vecs[i].ev));
      chk($sformatf("v%0d out_data", i), 128'(out_data), 128'(vecs[i].ed));
      chk($sformatf("v%0d out_track", i), 128'(out_track), 128'(trk(vecs[i].ed)));
      chk($sformatf("v%0d occupancy", i), 128'(occupancy), 128'(vecs[i].eocc));
      chk($sformatf("v%0d in_ready", i), 128'(in_ready), 128'(vecs[i].erdy));
      chk($sformatf("v%0d stall_cycles", i), 128'(stall_cycles), 128'(vecs[i].est));
      chk($sformatf("v%0d flush_drops", i), 128'(flush_drops), 128'(vecs[i].edr));
      step();
    end

    // Asynchronous reset with two entries held, checked before the next edge.
    drive(1'b1, 32'h51, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h52, 1'b0, 1'b0, 1'b0);
    step();
    chk("pre-reset occupancy", 128'(occupancy), 128'(2'd2));
    #2;
    nRST = 1'b0;
    #1;
    check_reset_outs("async reset");
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    #1;
    nRST = 1'b1;
    step();
    chk("post-reset out_valid", 128'(out_valid), 128'(1'b0));

    // Stall counting and saturation of the narrow counter.
    drive(1'b1, 32'h61, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) step();
    chk("stall5 stall_cycles", 128'(stall_cycles), 128'd5);
    chk("stall5 narrow stall_cycles", 128'(s_stall_cycles), 128'd5);
    chk("stall5 out_data held", 128'(out_data), 128'h61);
    chk("stall5 out_valid", 128'(out_valid), 128'(1'b1));
    for (int c = 0; c < 15; c++) step();
    chk("stall20 stall_cycles", 128'(stall_cycles), 128'd20);
    chk("stall20 narrow saturated", 128'(s_stall_cycles), 128'd15);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    chk("drain occupancy", 128'(occupancy), 128'(2'd0));
    chk("drain narrow no wrap", 128'(s_stall_cycles), 128'd15);
    chk("drain stall_cycles", 128'(stall_cycles), 128'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
